// File: rtl/sha256_compress_core_pkg.sv
// Shared definitions for the SHA-256 compression core: word type, FSM
// state encoding, round constant table and the 32-bit round functions
// (Ch, Maj, Sigma0/1, sigma0/1) used by the core and its message schedule.
// Bit numbering: packed vectors are [N-1:0]; the leftmost word (word 0)
// occupies the most significant 32 bits.
package sha256_compress_core_pkg;

  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL
  } state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress_core_if.sv
// Block-feeder <-> compression core bus.
//   start    : feeder requests compression of block_in with chaining value h_in
//   block_in : 512-bit message block, word 0 in bits [511:480]
//   h_in     : chaining value H0..H7, H0 in bits [255:224]
//   busy     : core is processing a block
//   done     : one-cycle pulse, h_out valid
//   h_out    : updated digest, same word order as h_in
interface sha256_compress_core_if;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] h_in;
  logic         busy;
  logic         done;
  logic [255:0] h_out;

  modport master (output start, block_in, h_in, input busy, done, h_out);
  modport slave  (input start, block_in, h_in, output busy, done, h_out);
endinterface

// File: rtl/sha256_msg_schedule.sv
// Sliding 16-word SHA-256 message schedule window.
//   clk, rst_n : clock, async active-low reset (window cleared)
//   load       : capture block_in into the window (word 0 from bits [511:480])
//   shift      : advance one round; new tail word is the W recurrence
//   block_in   : 512-bit message block
//   w_t        : current round's schedule word (window head)
module sha256_msg_schedule
  import sha256_compress_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block_in,
  output word_t        w_t
);

  word_t w [0:15];
  word_t w_next;

  // Evaluated every round; the values produced after round 48 are never consumed.
  always_comb begin
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < 16; i++) w[i] <= block_in[32*(15-i) +: 32];
    end else if (shift) begin
      for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
    end
  end

  assign w_t = w[0];

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression core: one round per clock over a..h.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of sha256_compress_core_if (start/block_in/h_in
//                in, busy/done/h_out out)
// Timing: START accepted at edge 0 -> LOAD, ROUNDS x ROUND, FINAL ->
// DONE high after edge ROUNDS+2. busy is high for LOAD and all ROUND cycles.
module sha256_compress_core
  import sha256_compress_core_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
)(
  input  logic                  clk,
  input  logic                  rst_n,
  sha256_compress_core_if.slave bus
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  state_t       state, state_nxt;
  logic [5:0]   t;
  logic         busy_q, done_q;
  logic [255:0] h_out_q;
  word_t        v    [0:7];   // a..h
  word_t        hold [0:7];
  word_t        w_t, t1, t2;
  logic         accept;

  assign accept = (state == ST_IDLE) && bus.start;

  sha256_msg_schedule u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift    (state == ST_ROUND),
    .block_in (bus.block_in),
    .w_t      (w_t)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_ROUND;
      ST_ROUND: if (t == T_LAST) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    t1 = v[7] + big_sigma1(v[4]) + ch(v[4], v[5], v[6]) + K[t] + w_t;
    t2 = big_sigma0(v[0]) + maj(v[0], v[1], v[2]);
  end

  // Operands are captured on the accepting edge so the feeder may change
  // block_in/h_in right after START; LOAD itself only arms the round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      t       <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      h_out_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        v[i]    <= '0;
        hold[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
              hold[i] <= bus.h_in[32*(7-i) +: 32];
              v[i]    <= bus.h_in[32*(7-i) +: 32];
            end
          end
        end
        ST_LOAD: t <= '0;
        ST_ROUND: begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          t    <= t + 1'b1;
          if (t == T_LAST) busy_q <= 1'b0;
        end
        ST_FINAL: begin
          for (int unsigned i = 0; i < 8; i++)
            h_out_q[32*(7-i) +: 32] <= hold[i] + v[i];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.h_out = h_out_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
module tb_sha256_compress_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sha256_compress_core_if bus ();

  sha256_compress_core #(.ROUNDS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight-line reference compression with a fully expanded W[0:63].
  function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [0:63];
    logic [31:0] s [0:7];
    logic [31:0] x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[32*(15-i) +: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) s[i] = hin[32*(7-i) +: 32];
    for (int i = 0; i < 64; i++) begin
      x1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
      x2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + x1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[32*(7-i) +: 32] = hin[32*(7-i) +: 32] + s[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives START now (caller is away from the edge), releases it after the
  // accepting edge and scrambles the operands; returns at the DONE sample.
  task automatic run_block(input string tag, input logic [511:0] blk, input logic [255:0] hin,
                           input logic [255:0] prev, input int pulse_at,
                           output int lat, output int busy_cyc);
    bus.start    = 1'b1;
    bus.block_in = blk;
    bus.h_in     = hin;
    @(posedge clk); #1;
    bus.block_in = ~blk;
    bus.h_in     = ~hin;
    lat      = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      bus.start = (lat == pulse_at);
      if (bus.busy === 1'b1) busy_cyc++;
      if (lat == 30) chk({tag, "_hold"}, bus.h_out, prev);
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, 256'(bus.done), 256'(1));
  endtask

  logic [511:0] blk_abc, blk_empty, blk_c1, blk_c2;
  logic [255:0] dig_abc, dig_empty, dig_chain, hmid;
  int lat, busy_cyc, ndone;

  initial begin
    blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
    blk_empty = {32'h80000000, 480'h0};
    blk_c1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_c2    = {480'h0, 32'h000001c0};
    dig_abc   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    dig_empty = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    dig_chain = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    bus.start = 1'b0; bus.block_in = '0; bus.h_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  256'(bus.busy), 256'(0));
    chk("rst_done",  256'(bus.done), 256'(0));
    chk("rst_h_out", bus.h_out, 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc": latency, busy length, single-cycle DONE
    run_block("abc", blk_abc, H0, 256'(0), -1, lat, busy_cyc);
    chk("abc_digest",  bus.h_out, dig_abc);
    chk("abc_latency", 256'(lat), 256'(66));
    chk("abc_busy",    256'(busy_cyc), 256'(65));
    @(posedge clk); #1;
    chk("abc_done_pulse", 256'(bus.done), 256'(0));

    // Empty message with a stray START at cycle 10
    run_block("empty", blk_empty, H0, dig_abc, 10, lat, busy_cyc);
    chk("empty_digest",  bus.h_out, dig_empty);
    chk("empty_latency", 256'(lat), 256'(66));
    ndone = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("empty_extra_done", 256'(ndone), 256'(0));

    // Two-block chain, block 2 started on block 1's DONE cycle
    hmid = ref_compress(blk_c1, H0);
    run_block("chain1", blk_c1, H0, dig_empty, -1, lat, busy_cyc);
    chk("chain1_digest", bus.h_out, hmid);
    run_block("chain2", blk_c2, bus.h_out, hmid, -1, lat, busy_cyc);
    chk("chain2_b2b_latency", 256'(lat), 256'(66));
    chk("chain_digest", bus.h_out, dig_chain);

    // Wrap-around of every word add
    run_block("wrap", 512'h0, {8{32'hffffffff}}, dig_chain, -1, lat, busy_cyc);
    chk("wrap_digest",  bus.h_out, ref_compress(512'h0, {8{32'hffffffff}}));
    chk("wrap_busy",    256'(busy_cyc), 256'(65));
    chk("wrap_latency", 256'(lat), 256'(66));

    // Abort mid-ROUND at t=20
    @(posedge clk); #1;
    bus.start = 1'b1; bus.block_in = blk_abc; bus.h_in = H0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  256'(bus.busy), 256'(0));
    chk("abort_done",  256'(bus.done), 256'(0));
    chk("abort_h_out", bus.h_out, 256'(0));
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 256'(ndone), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
